// File: rtl/mux_pkg.sv
// mux_pkg: shared default width and data type for the mux2_cell family
package mux_pkg;
  localparam int WIDTH_DEF = 1;
  typedef logic [WIDTH_DEF-1:0] data_t;
endpackage

// File: rtl/mux2_cell_if.sv
// mux2_cell_if: data/select bundle of a mux2_cell (in0, in1, sel in; out, out_q back)
interface mux2_cell_if #(parameter int WIDTH = mux_pkg::WIDTH_DEF);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  modport master (output in0, in1, sel, input out, out_q);
  modport slave (input in0, in1, sel, output out, out_q);
endinterface

// File: rtl/mux2_cell.sv
// mux2_cell: 2:1 mux leaf cell; ports out/in0/in1/sel (combinational, sel ? in1 : in0), clk/rst_n, out_q (out registered, async active-low reset to RESET_VAL)
module mux2_cell
  import mux_pkg::*;
#(
  parameter int               WIDTH     = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out_q
);
  assign out = sel ? in1 : in0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_q <= RESET_VAL;
    else out_q <= out;
endmodule

// File: tb/tb_mux2_cell.sv
// tb_mux2_cell: self-checking bench for mux2_cell (truth table, 8-bit paths, async reset, 8:1 tree)
module tb_mux2_cell;
  import mux_pkg::*;
  localparam logic [7:0] RV = 8'h5A;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mux2_cell_if #(.WIDTH(8)) bus ();
  mux2_cell #(.WIDTH(8), .RESET_VAL(RV)) dut (
    .out(bus.out), .in0(bus.in0), .in1(bus.in1), .sel(bus.sel),
    .clk(clk), .rst_n(rst_n), .out_q(bus.out_q)
  );
  logic a0, a1, as, ay, ayq;
  mux2_cell #(.WIDTH(1)) d1 (
    .out(ay), .in0(a0), .in1(a1), .sel(as), .clk(clk), .rst_n(rst_n), .out_q(ayq)
  );
  logic [7:0] ti;
  logic [2:0] ts;
  logic [3:0] l0;
  logic [1:0] l1;
  logic       t_out;
  logic [6:0] tq;
  for (genvar g = 0; g < 4; g++) begin : g_l0
    mux2_cell #(.WIDTH(1)) c (
      .out(l0[g]), .in0(ti[2*g]), .in1(ti[2*g+1]), .sel(ts[0]),
      .clk(clk), .rst_n(rst_n), .out_q(tq[g])
    );
  end
  for (genvar g = 0; g < 2; g++) begin : g_l1
    mux2_cell #(.WIDTH(1)) c (
      .out(l1[g]), .in0(l0[2*g]), .in1(l0[2*g+1]), .sel(ts[1]),
      .clk(clk), .rst_n(rst_n), .out_q(tq[4+g])
    );
  end
  mux2_cell #(.WIDTH(1)) c_top (
    .out(t_out), .in0(l1[0]), .in1(l1[1]), .sel(ts[2]),
    .clk(clk), .rst_n(rst_n), .out_q(tq[6])
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  typedef struct {
    logic s;
    logic i0;
    logic i1;
    logic y;
  } vec_t;
  vec_t tv[8];
  logic [7:0] pick[2];
  logic [7:0] exp_q;
  logic [7:0] m;
  initial begin
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bus.in0 = 8'hA5;
    bus.in1 = 8'h3C;
    bus.sel = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    as = 1'b0;
    ti = '0;
    ts = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", bus.out_q, RV);
    for (int i = 0; i < 8; i++) begin
      as = tv[i].s;
      a0 = tv[i].i0;
      a1 = tv[i].i1;
      #1 chk($sformatf("truth_%0d", i), {7'b0, ay}, {7'b0, tv[i].y});
    end
    for (int i = 0; i < 4; i++) begin
      bus.sel = i[0];
      #1 chk("comb_toggle", bus.out, i[0] ? 8'h3C : 8'hA5);
      chk("reset_hold", bus.out_q, RV);
    end
    @(negedge clk);
    bus.sel = 1'b1;
    rst_n = 1'b1;
    #1 chk("release_no_edge", bus.out_q, RV);
    @(posedge clk);
    #1 chk("reg_first_edge", bus.out_q, 8'h3C);
    bus.sel = 1'b0;
    #1 chk("reg_hold", bus.out_q, 8'h3C);
    chk("comb_after_sel", bus.out, 8'hA5);
    @(posedge clk);
    #1 chk("reg_next_edge", bus.out_q, 8'hA5);
    #2 rst_n = 1'b0;
    #1 chk("reset_midcycle", bus.out_q, RV);
    @(posedge clk);
    #1 chk("reset_held_edge", bus.out_q, RV);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sel = 1'b1;
    #1 chk("release_wait", bus.out_q, RV);
    @(posedge clk);
    #1 chk("release_load", bus.out_q, 8'h3C);
    bus.in0 = 8'hF0;
    bus.in1 = 8'hF5;
    bus.sel = 1'bx;
    m = ~(bus.in0 ^ bus.in1);
    #1 chk("selx_common_bits", bus.out & m, 8'hF0 & m);
    bus.sel = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus.in0 = 8'($urandom);
      bus.in1 = 8'($urandom);
      bus.sel = 1'($urandom);
      pick[0] = bus.in0;
      pick[1] = bus.in1;
      exp_q = pick[bus.sel];
      #1 chk("rand_comb", bus.out, exp_q);
      if ($urandom_range(15) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_reset", bus.out_q, RV);
        chk("rand_comb_in_reset", bus.out, exp_q);
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1 chk("rand_reg", bus.out_q, exp_q);
    end
    for (int i = 0; i < 8; i++) begin
      ts = 3'(i);
      ti = 8'b1 << i;
      #1 chk($sformatf("tree_onehot_%0d", i), {7'b0, t_out}, 8'd1);
      ti = ~(8'b1 << i);
      #1 chk($sformatf("tree_onecold_%0d", i), {7'b0, t_out}, 8'd0);
    end
    for (int i = 0; i < 32; i++) begin
      ts = 3'($urandom);
      ti = 8'($urandom);
      #1 chk("tree_rand", {7'b0, t_out}, {7'b0, ti[ts]});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
